// File: rtl/result_checker.sv
// Pairwise scoreboard: compares expected/actual streams, counts pass/fail, logs mismatches in a FIFO.
// Results visible one cycle after the accepting edge; pairs are held off while the log FIFO is full.
module result_checker #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int LOG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [DATA_W-1:0]         exp_data,
    input  logic                      act_valid,
    output logic                      act_ready,
    input  logic [DATA_W-1:0]         act_data,
    output logic [2*CNT_W-1:0]        stats,
    output logic [CNT_W-1:0]          first_fail_idx,
    output logic                      any_fail,
    output logic                      log_valid,
    input  logic                      log_ready,
    output logic [CNT_W+2*DATA_W-1:0] log_data
);
    localparam int AW    = $clog2(LOG_DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = CNT_W + 2 * DATA_W;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             any_fail_q, any_fail_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [REC_W-1:0] mem_q [LOG_DEPTH];
    logic [REC_W-1:0] mem_d [LOG_DEPTH];

    logic log_full;
    logic fire;
    logic push;
    logic pop;

    // Full stalls the pair even when a pop is pending this cycle, so ready never depends on log_ready.
    assign log_full  = (cnt_q == FULL_CNT);
    assign fire      = exp_valid & act_valid & ~log_full & ~rst & ~clear;
    assign exp_ready = fire;
    assign act_ready = fire;
    assign push      = fire & (exp_data != act_data);
    assign log_valid = (cnt_q != '0);
    assign pop       = log_valid & log_ready;

    always_comb begin
        pass_cnt_d       = pass_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        idx_d            = idx_q;
        first_fail_idx_d = first_fail_idx_q;
        any_fail_d       = any_fail_q;
        if (fire) begin
            idx_d = idx_q + CNT_W'(1);
            if (push) begin
                if (fail_cnt_q != '1) begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                end
                if (!any_fail_q) begin
                    first_fail_idx_d = idx_q;
                    any_fail_d       = 1'b1;
                end
            end else if (pass_cnt_q != '1) begin
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {idx_q, exp_data, act_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            idx_q            <= '0;
            first_fail_idx_q <= '0;
            any_fail_q       <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
        end else begin
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            idx_q            <= idx_d;
            first_fail_idx_q <= first_fail_idx_d;
            any_fail_q       <= any_fail_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign stats          = {pass_cnt_q, fail_cnt_q};
    assign first_fail_idx = first_fail_idx_q;
    assign any_fail       = any_fail_q;
    assign log_data       = mem_q[rd_ptr_q];

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Hardware scoreboard for the LOG_SHIFT bench.
- Consumes two valid/ready streams, expected and actual, and compares them pair by pair.
- Accumulates pass/fail counts in the packed layout {pass_cnt, fail_cnt} used by the bench's test_stats struct.
- Queues mismatch records in a small FIFO so the bench can drain and print them with VERB_NONE/VERB_LOW reports.

Parameters:
- DATA_W, 32, width of expected/actual data words.
- CNT_W, 32, width of pass/fail/index counters. 32 matches int unsigned.
- LOG_DEPTH, 4, mismatch FIFO depth in entries. Power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous statistics clear; same effect as rst on all state.
- exp_valid  in  1  expected word valid.
- exp_ready  out  1  expected word accepted.
- exp_data  in  DATA_W  expected word.
- act_valid  in  1  actual (DUT) word valid.
- act_ready  out  1  actual word accepted.
- act_data  in  DATA_W  actual word.
- stats  out  2*CNT_W  {pass_cnt, fail_cnt}; pass_cnt in the upper half.
- first_fail_idx  out  CNT_W  pair index of the first mismatch since reset/clear.
- any_fail  out  1  sticky; set on the first mismatch.
- log_valid  out  1  mismatch record available.
- log_ready  in  1  bench consumes the record.
- log_data  out  CNT_W+2*DATA_W  {idx, exp, act} of the mismatch.

Behaviour:
- Reset/clear: stats=0, first_fail_idx=0, any_fail=0, pair index=0, FIFO emptied (log_valid=0). exp_ready and act_ready are 0 during any cycle with rst or clear high.
- Ready rules:
  - fire = exp_valid & act_valid & !log_full & !rst & !clear.
  - exp_ready = act_ready = fire.
  - Both streams are consumed atomically; one side is never consumed alone.
  - Ready may depend on valid; valid never depends on ready.
  - Full blocks even if the pair would match. This is conservative and independent of data.
- On a fire edge, compare exp_data with act_data (full DATA_W equality, X treated as mismatch by the bench, not the RTL):
  - Match: pass_cnt += 1.
  - Mismatch: fail_cnt += 1. Push {idx, exp_data, act_data}. If any_fail=0, then first_fail_idx <= idx and any_fail <= 1.
  - In either case idx += 1.
- Latency: stats, any_fail and first_fail_idx reflect a pair one cycle after its fire edge. A pushed record appears on log_valid/log_data that same following cycle (first-word fall-through).
- Counter widths:
  - pass_cnt and fail_cnt saturate at 2^CNT_W-1 and hold.
  - idx wraps modulo 2^CNT_W; saturation does not stop idx.
- FIFO:
  - Pop on log_valid & log_ready.
  - log_data holds stable while log_valid=1 and log_ready=0.
  - Push and pop in the same cycle, when not full: occupancy unchanged, order preserved.
  - Full: fire blocked regardless of a same-cycle pop. The slot frees the next cycle.
  - Empty: log_ready ignored; log_data is don't-care.
- Reset or clear mid-stream:
  - Any pair presented that cycle is not consumed.
  - Queued records are discarded.
  - The counter update from a fire on the previous edge is overwritten by the clear.
- No state machine beyond the FIFO pointers, counters and sticky flag. All state updates occur only on the clk rising edge.

Test Plan:
- Reset, then 8 pairs exp=act=i (i=0..7), log_ready=1 -> stats={8,0}, any_fail=0, log_valid never 1.
- Pairs 0..5 with act≠exp at idx 2 and 4 (exp=2, act=0xDEAD) -> stats={4,2}, first_fail_idx=2, two log records {2,2,0xDEAD} and {4,4,...} in order.
- log_ready=0, 6 consecutive mismatches, LOG_DEPTH=4 -> 4 accepted, then exp_ready=act_ready=0 with valids high. Raise log_ready -> records drain in index order 0..3, remaining 2 pairs accepted, final fail_cnt=6.
- exp_valid=1 with act_valid=0 for 5 cycles -> no handshake, stats unchanged. Then act_valid=1 -> exactly one pair consumed.
- Preload pass_cnt near saturation (CNT_W=4 build, 17 matching pairs) -> pass_cnt=15 held, idx wrapped to 1.
- Assert clear for 1 cycle with both valids high and 2 records queued -> no pair consumed that cycle, stats=0, any_fail=0, log_valid=0 the next cycle.
